// File: rtl/dev_command_router_if.sv
// Command/device/TX signal bundle between uart_rx_controller, the router and its sub-devices.
// slave is the router's view; master is the view of the surrounding logic.
interface dev_command_router_if #(
  parameter int NUM_DEV = 4
);
  logic                   dev_command_started;
  logic                   dev_command_processing;
  logic [7:0]             dev_command;
  logic                   dev_command_data_signal;
  logic                   dev_busy;
  logic [NUM_DEV-1:0]     dev_started_o;
  logic [NUM_DEV-1:0]     dev_processing_o;
  logic [NUM_DEV-1:0]     dev_data_signal_o;
  logic [NUM_DEV-1:0]     dev_busy_i;
  logic [NUM_DEV-1:0]     tx_send_i;
  logic [8*NUM_DEV-1:0]   tx_byte_i;
  logic                   uart_tx_send_byte;
  logic [7:0]             uart_tx_byte;
  logic                   uart_tx_active;

  modport slave (
    input  dev_command_started, dev_command_processing, dev_command,
           dev_command_data_signal, dev_busy_i, tx_send_i, tx_byte_i, uart_tx_active,
    output dev_busy, dev_started_o, dev_processing_o, dev_data_signal_o,
           uart_tx_send_byte, uart_tx_byte
  );

  modport master (
    output dev_command_started, dev_command_processing, dev_command,
           dev_command_data_signal, dev_busy_i, tx_send_i, tx_byte_i, uart_tx_active,
    input  dev_busy, dev_started_o, dev_processing_o, dev_data_signal_o,
           uart_tx_send_byte, uart_tx_byte
  );
endinterface

// File: rtl/dev_command_router.sv
// Routes uart_rx commands to one of NUM_DEV sub-devices, with a per-command watchdog and locked TX ownership.
// Optional: define CMD_ROUTER_NACK_EN to answer unmapped commands with NACK_BYTE.
module dev_command_router #(
  parameter int         NUM_DEV    = 4,
  parameter int         SEL_BITS   = 3,
  parameter int         DEV_BASE   = 2,
  parameter int         TIMEOUT_MS = 1000,
  parameter logic [7:0] NACK_BYTE  = 8'hEE
) (
  input  logic clock,
  input  logic reset,
  input  logic signal_1ms,
  output logic timeout_error,
  output logic tx_conflict,
  dev_command_router_if.slave bus
);
  localparam int OW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, NACK} state_t;

  state_t              state, state_nxt;
  logic [OW-1:0]       owner, tx_owner, sel;
  logic [15:0]         ms_cnt;
  logic [SEL_BITS-1:0] field;
  logic                sel_valid, cmd_accept, conflict_hit;
  logic [NUM_DEV-1:0]  tx_allowed;
  logic                unused_bits;

  assign field      = bus.dev_command[7 -: SEL_BITS];
  assign sel_valid  = (int'(field) >= DEV_BASE) && (int'(field) < DEV_BASE + NUM_DEV);
  assign sel        = OW'(int'(field) - DEV_BASE);
  // No device is ever pulsed in a cycle where reset is asserted.
  assign cmd_accept = (state == IDLE) && bus.dev_command_started && sel_valid && !reset;
  assign unused_bits = ^{bus.dev_command, NACK_BYTE, bus.uart_tx_active};

  always_comb begin
    state_nxt             = state;
    bus.dev_started_o     = '0;
    bus.dev_processing_o  = '0;
    bus.dev_data_signal_o = '0;
    bus.dev_busy          = |bus.dev_busy_i;
    timeout_error         = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          bus.dev_started_o[sel] = 1'b1;
          state_nxt              = ACTIVE;
        end
`ifdef CMD_ROUTER_NACK_EN
        else if (bus.dev_command_started && !sel_valid && !reset) begin
          state_nxt = NACK;
        end
`endif
      end
      ACTIVE: begin
        bus.dev_processing_o[owner]  = bus.dev_command_processing;
        bus.dev_data_signal_o[owner] = bus.dev_command_data_signal;
        bus.dev_busy                 = bus.dev_busy_i[owner];
        // A normal completion in the same cycle wins over the watchdog.
        if (!bus.dev_command_processing && !bus.dev_busy_i[owner]) begin
          state_nxt = IDLE;
        end else if ((TIMEOUT_MS != 0) && signal_1ms && !reset &&
                     ((32'(ms_cnt) + 32'd1) >= 32'(TIMEOUT_MS))) begin
          timeout_error = 1'b1;
          state_nxt     = IDLE;
        end
      end
`ifdef CMD_ROUTER_NACK_EN
      NACK: begin
        bus.dev_busy = 1'b1;
        if (!bus.uart_tx_active) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // TX mux follows tx_owner, which survives a watchdog abort so late bytes still drain.
  always_comb begin
    tx_allowed            = NUM_DEV'(1) << tx_owner;
    bus.uart_tx_send_byte = bus.tx_send_i[tx_owner];
    bus.uart_tx_byte      = bus.tx_byte_i[8*tx_owner +: 8];
`ifdef CMD_ROUTER_NACK_EN
    if (state == NACK) begin
      tx_allowed            = '0;
      bus.uart_tx_send_byte = !bus.uart_tx_active;
      bus.uart_tx_byte      = NACK_BYTE;
    end
`endif
    conflict_hit = |(bus.tx_send_i & ~tx_allowed);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      tx_owner    <= '0;
      ms_cnt      <= '0;
      tx_conflict <= 1'b0;
    end else begin
      state <= state_nxt;
      if (conflict_hit) tx_conflict <= 1'b1;
      if (cmd_accept) begin
        owner    <= sel;
        tx_owner <= sel;
        ms_cnt   <= '0;
      end else if ((state == ACTIVE) && signal_1ms && (ms_cnt != 16'hFFFF)) begin
        ms_cnt <= ms_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dev_command_router.sv
// Self-checking bench for dev_command_router: directed scenarios plus random traffic against a command-level model.
// Define CMD_ROUTER_NACK_EN for both bench and RTL to exercise the NACK path.
module tb_dev_command_router;
  localparam int ND  = 4;
  localparam int TMO = 3;
`ifdef CMD_ROUTER_NACK_EN
  localparam bit NACK_EN = 1'b1;
`else
  localparam bit NACK_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic signal_1ms = 1'b0;
  logic timeout_error, tx_conflict;

  dev_command_router_if #(.NUM_DEV(ND)) bus ();

  dev_command_router #(
    .NUM_DEV(ND), .SEL_BITS(3), .DEV_BASE(2), .TIMEOUT_MS(TMO), .NACK_BYTE(8'hEE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .signal_1ms(signal_1ms),
    .timeout_error(timeout_error),
    .tx_conflict(tx_conflict),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: is a command running, who owns it, how many ms ticks it has seen.
  bit m_active, m_nack, m_conf;
  int m_owner, m_txo, m_ticks;
  // Decisions taken in eval() and applied at the following edge.
  bit s_accept, s_nack_go, s_end, s_conflict;
  int s_dev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.dev_command_started     = 1'b0;
    bus.dev_command_processing  = 1'b0;
    bus.dev_command             = 8'h00;
    bus.dev_command_data_signal = 1'b0;
    bus.dev_busy_i              = '0;
    bus.tx_send_i               = '0;
    bus.tx_byte_i               = '0;
    bus.uart_tx_active          = 1'b0;
    signal_1ms                  = 1'b0;
  endtask

  task automatic eval();
    int f;
    bit v, done, fire;
    logic [ND-1:0] e_st, e_pr, e_da, allowed;
    logic e_busy, e_send;
    logic [7:0] e_byte;
    #1;
    f = int'(bus.dev_command) / 32;
    v = (f >= 2) && (f < 2 + ND);
    e_st = '0; e_pr = '0; e_da = '0;
    s_accept  = !m_active && !m_nack && bus.dev_command_started && v && !reset;
    s_nack_go = NACK_EN && !m_active && !m_nack && bus.dev_command_started && !v && !reset;
    s_dev     = f - 2;
    if (s_accept) e_st[s_dev] = 1'b1;
    done = 1'b0;
    fire = 1'b0;
    if (m_active) begin
      e_pr[m_owner] = bus.dev_command_processing;
      e_da[m_owner] = bus.dev_command_data_signal;
      e_busy = bus.dev_busy_i[m_owner];
      done   = !bus.dev_command_processing && !bus.dev_busy_i[m_owner];
      fire   = !done && signal_1ms && (m_ticks + 1 == TMO) && !reset;
    end else begin
      e_busy = m_nack ? 1'b1 : |bus.dev_busy_i;
    end
    s_end = done || fire;
    if (m_nack) begin
      e_send  = !bus.uart_tx_active;
      e_byte  = 8'hEE;
      allowed = '0;
    end else begin
      e_send  = bus.tx_send_i[m_txo];
      e_byte  = bus.tx_byte_i[8*m_txo +: 8];
      allowed = '0;
      allowed[m_txo] = 1'b1;
    end
    s_conflict = |(bus.tx_send_i & ~allowed);
    chk("started", bus.dev_started_o, e_st);
    chk("processing", bus.dev_processing_o, e_pr);
    chk("data", bus.dev_data_signal_o, e_da);
    chk("busy", bus.dev_busy, e_busy);
    chk("timeout", timeout_error, fire);
    chk("tx_send", bus.uart_tx_send_byte, e_send);
    chk("tx_byte", bus.uart_tx_byte, e_byte);
    chk("conflict", tx_conflict, m_conf);
  endtask

  task automatic tick();
    if (reset) begin
      m_active = 0; m_nack = 0; m_conf = 0; m_owner = 0; m_txo = 0; m_ticks = 0;
    end else begin
      if (s_conflict) m_conf = 1;
      if (m_active) begin
        if (s_end) m_active = 0;
        else if (signal_1ms) m_ticks++;
      end else if (m_nack) begin
        if (!bus.uart_tx_active) m_nack = 0;
      end else if (s_accept) begin
        m_active = 1; m_owner = s_dev; m_txo = s_dev; m_ticks = 0;
      end else if (s_nack_go) begin
        m_nack = 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cyc();
    eval();
    tick();
  endtask

  task automatic start_cmd(input logic [7:0] cmd, input logic [ND-1:0] exp, input string tag);
    bus.dev_command_started = 1'b1;
    bus.dev_command         = cmd;
    eval();
    chk(tag, bus.dev_started_o, exp);
    tick();
    bus.dev_command_started = 1'b0;
  endtask

  initial begin
    idle_inputs();
    m_active = 0; m_nack = 0; m_conf = 0; m_owner = 0; m_txo = 0; m_ticks = 0;
    @(posedge clock); #1;
    cyc(); cyc();
    reset = 1'b0;

    eval();
    chk("rst_outputs", {bus.dev_started_o, bus.dev_processing_o, bus.dev_data_signal_o,
                        bus.dev_busy, bus.uart_tx_send_byte, bus.uart_tx_byte}, 0);
    chk("rst_flags", {timeout_error, tx_conflict}, 0);
    tick();

    // Routing: 8'h45 selects device 0, payload strobes go only there.
    bus.dev_command_processing = 1'b1;
    start_cmd(8'h45, 4'b0001, "route_started");
    for (int i = 0; i < 3; i++) begin
      bus.dev_command_data_signal = 1'b1;
      eval();
      chk("route_data", bus.dev_data_signal_o, 4'b0001);
      tick();
      bus.dev_command_data_signal = 1'b0;
      cyc();
    end
    bus.dev_command_processing = 1'b0;
    bus.dev_busy_i = 4'b0001;
    eval();
    chk("route_busy", bus.dev_busy, 1);
    tick();
    bus.dev_busy_i = 4'b0000;
    cyc();
    bus.dev_command_processing = 1'b1;
    eval();
    chk("route_idle", bus.dev_processing_o, 0);
    tick();
    bus.dev_command_processing = 1'b0;

    // Select field edges.
    start_cmd(8'h20, 4'b0000, "sel_low");
    cyc(); cyc();
    start_cmd(8'hC0, 4'b0000, "sel_high");
    cyc(); cyc();
    start_cmd(8'hA0, 4'b1000, "sel_top");
    cyc(); cyc();

    // Watchdog: device 1 never releases busy.
    bus.dev_busy_i = 4'b0010;
    start_cmd(8'h60, 4'b0010, "wd_start");
    for (int t = 1; t <= TMO; t++) begin
      cyc(); cyc();
      signal_1ms = 1'b1;
      eval();
      chk("wd_tick", timeout_error, (t == TMO));
      tick();
      signal_1ms = 1'b0;
    end
    bus.dev_busy_i = 4'b0100;
    eval();
    chk("wd_busy_or", bus.dev_busy, 1);
    tick();
    bus.dev_busy_i = 4'b0000;
    eval();
    chk("wd_busy_clr", bus.dev_busy, 0);
    tick();
    start_cmd(8'h60, 4'b0010, "wd_next_cmd");
    cyc(); cyc();

    // TX ownership: device 2 owns the UART, device 0 strobes alongside.
    bus.dev_command_processing = 1'b1;
    start_cmd(8'h80, 4'b0100, "tx_start");
    bus.tx_byte_i = {8'h00, 8'h55, 8'h00, 8'hAA};
    bus.tx_send_i = 4'b0101;
    eval();
    chk("tx_owner_send", bus.uart_tx_send_byte, 1);
    chk("tx_owner_byte", bus.uart_tx_byte, 8'h55);
    tick();
    bus.tx_send_i = 4'b0000;
    eval();
    chk("tx_conflict_set", tx_conflict, 1);
    tick();
    bus.dev_command_processing = 1'b0;
    repeat (4) cyc();
    eval();
    chk("tx_conflict_sticky", tx_conflict, 1);
    tick();

    // Reset in the middle of a payload.
    bus.dev_command_processing = 1'b1;
    start_cmd(8'h45, 4'b0001, "mr_start");
    bus.dev_command_data_signal = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.dev_command_data_signal = 1'b0;
    eval();
    chk("mr_outputs", {bus.dev_processing_o, bus.dev_data_signal_o, bus.dev_busy,
                       timeout_error, tx_conflict}, 0);
    tick();
    start_cmd(8'h45, 4'b0001, "mr_restart");
    bus.dev_command_processing = 1'b0;
    cyc(); cyc();

    // Unmapped command 8'hE0 while the UART is busy.
    start_cmd(8'hE0, 4'b0000, "nack_start");
    bus.uart_tx_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      eval();
      chk("nack_wait_busy", bus.dev_busy, NACK_EN);
      chk("nack_wait_send", bus.uart_tx_send_byte, 0);
      tick();
    end
    bus.uart_tx_active = 1'b0;
    eval();
    chk("nack_send", bus.uart_tx_send_byte, NACK_EN);
    if (NACK_EN) chk("nack_byte", bus.uart_tx_byte, 8'hEE);
    tick();
    eval();
    chk("nack_done_busy", bus.dev_busy, 0);
    chk("nack_done_send", bus.uart_tx_send_byte, 0);
    tick();

    // Random traffic against the model.
    repeat (3000) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.dev_command_started     = ($urandom_range(0, 7) == 0);
      bus.dev_command             = 8'($urandom);
      bus.dev_command_data_signal = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) bus.dev_command_processing = ~bus.dev_command_processing;
      for (int b = 0; b < ND; b++) begin
        if ($urandom_range(0, 9) == 0) bus.dev_busy_i[b] = ~bus.dev_busy_i[b];
        bus.tx_send_i[b] = ($urandom_range(0, 15) == 0);
      end
      bus.tx_byte_i      = 32'($urandom);
      bus.uart_tx_active = ($urandom_range(0, 2) == 0);
      signal_1ms         = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
